osd_nasti_lite_master: RTL and testbench

- Single-outstanding NASTI-lite master; the initiator end of the NASTI slave interface used by the OSD DEM UART path.
- Converts a simple request/response bus from OSD debug logic (e.g. memory-access or test modules) into NASTI AW/W/B and AR/R transactions.
- Returns read data and response status to the requester.

---
 rtl/osd_nasti_lite_master_if.sv | 81 ++++++++
 rtl/osd_nasti_lite_master.sv | 118 +++++++++++
 tb/tb_osd_nasti_lite_master.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/osd_nasti_lite_master_if.sv
// Request/response and NASTI-lite channel bundle for osd_nasti_lite_master.
// master is the bridge's view; slave is the requester plus the bus slave.
interface osd_nasti_lite_master_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_strb;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic [1:0]              resp_code;

    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_strb,
        output req_ready,
        output resp_valid, resp_rdata, resp_code,
        input  resp_ready,
        output aw_id, aw_addr, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_strb,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_code,
        output resp_ready,
        input  aw_id, aw_addr, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/osd_nasti_lite_master.sv
// Single-outstanding NASTI-lite master: turns a request/response bus
// from OSD debug logic into AW/W/B and AR/R transactions.
module osd_nasti_lite_master #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    osd_nasti_lite_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        WR,
        WAIT_B,
        RD,
        WAIT_R,
        RESP
    } state_t;

    state_t state;
    logic   aw_keep;
    logic   w_keep;
    logic   unused_inputs;

    assign bus.aw_id  = {ID_WIDTH{1'b0}};
    assign bus.ar_id  = {ID_WIDTH{1'b0}};
    assign bus.w_last = 1'b1;

    assign unused_inputs = ^{bus.b_id, bus.r_id, bus.r_last};

    // A channel stays valid only while its handshake is still pending.
    assign aw_keep = bus.aw_valid & ~bus.aw_ready;
    assign w_keep  = bus.w_valid & ~bus.w_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= {DATA_WIDTH{1'b0}};
            bus.resp_code  <= 2'b00;
            bus.aw_valid   <= 1'b0;
            bus.aw_addr    <= {ADDR_WIDTH{1'b0}};
            bus.w_valid    <= 1'b0;
            bus.w_data     <= {DATA_WIDTH{1'b0}};
            bus.w_strb     <= {(DATA_WIDTH/8){1'b0}};
            bus.b_ready    <= 1'b0;
            bus.ar_valid   <= 1'b0;
            bus.ar_addr    <= {ADDR_WIDTH{1'b0}};
            bus.r_ready    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        bus.aw_addr   <= bus.req_addr;
                        bus.ar_addr   <= bus.req_addr;
                        bus.w_data    <= bus.req_wdata;
                        bus.w_strb    <= bus.req_strb;
                        if (bus.req_we) begin
                            bus.aw_valid <= 1'b1;
                            bus.w_valid  <= 1'b1;
                            state        <= WR;
                        end else begin
                            bus.ar_valid <= 1'b1;
                            state        <= RD;
                        end
                    end
                end
                WR: begin
                    bus.aw_valid <= aw_keep;
                    bus.w_valid  <= w_keep;
                    if (!aw_keep && !w_keep) begin
                        bus.b_ready <= 1'b1;
                        state       <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.b_valid) begin
                        bus.b_ready    <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= {DATA_WIDTH{1'b0}};
                        bus.resp_code  <= bus.b_resp;
                        state          <= RESP;
                    end
                end
                RD: begin
                    if (bus.ar_ready) begin
                        bus.ar_valid <= 1'b0;
                        bus.r_ready  <= 1'b1;
                        state        <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (bus.r_valid) begin
                        bus.r_ready    <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= bus.r_data;
                        bus.resp_code  <= bus.r_resp;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_osd_nasti_lite_master.sv
// Bench for osd_nasti_lite_master: transaction-phase model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_osd_nasti_lite_master;
    localparam int IW = 1;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    osd_nasti_lite_master_if #(
        .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) bus ();

    osd_nasti_lite_master #(
        .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Transaction-phase model: which phases of the outstanding
    // transaction are still owed, and the captured response.
    bit          m_busy, m_wr, m_aw, m_w, m_ar, m_have;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_strb;
    logic [1:0]    m_code;

    function automatic bit e_aw();
        return m_busy && m_wr && m_aw;
    endfunction
    function automatic bit e_w();
        return m_busy && m_wr && m_w;
    endfunction
    function automatic bit e_b();
        return m_busy && m_wr && !m_aw && !m_w && !m_have;
    endfunction
    function automatic bit e_ar();
        return m_busy && !m_wr && m_ar;
    endfunction
    function automatic bit e_r();
        return m_busy && !m_wr && !m_ar && !m_have;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_wr = 0; m_aw = 0; m_w = 0; m_ar = 0; m_have = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_strb = '0; m_code = '0;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("req_ready", bus.req_ready, !m_busy);
        chk("aw_valid", bus.aw_valid, e_aw());
        chk("w_valid", bus.w_valid, e_w());
        chk("b_ready", bus.b_ready, e_b());
        chk("ar_valid", bus.ar_valid, e_ar());
        chk("r_ready", bus.r_ready, e_r());
        chk("resp_valid", bus.resp_valid, m_have);
        chk("aw_id", bus.aw_id, 0);
        chk("ar_id", bus.ar_id, 0);
        chk("w_last", bus.w_last, 1);
        if (e_aw()) chk("aw_addr", bus.aw_addr, m_addr);
        if (e_w()) begin
            chk("w_data", bus.w_data, m_wdata);
            chk("w_strb", bus.w_strb, m_strb);
        end
        if (e_ar()) chk("ar_addr", bus.ar_addr, m_addr);
        if (m_have) begin
            chk("resp_rdata", bus.resp_rdata, m_rdata);
            chk("resp_code", bus.resp_code, m_code);
        end
    endtask

    task automatic model_update();
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs, resp_hs;
        aw_hs   = e_aw() && bus.aw_ready;
        w_hs    = e_w() && bus.w_ready;
        ar_hs   = e_ar() && bus.ar_ready;
        b_hs    = e_b() && bus.b_valid;
        r_hs    = e_r() && bus.r_valid;
        resp_hs = m_have && bus.resp_ready;
        if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy  = 1;
                m_wr    = bus.req_we;
                m_aw    = bus.req_we;
                m_w     = bus.req_we;
                m_ar    = !bus.req_we;
                m_addr  = bus.req_addr;
                m_wdata = bus.req_wdata;
                m_strb  = bus.req_strb;
            end
        end else begin
            if (aw_hs) m_aw = 0;
            if (w_hs) m_w = 0;
            if (ar_hs) m_ar = 0;
            if (b_hs) begin
                m_have = 1; m_rdata = '0; m_code = bus.b_resp;
            end
            if (r_hs) begin
                m_have = 1; m_rdata = bus.r_data; m_code = bus.r_resp;
            end
            if (resp_hs) begin
                m_busy = 0; m_have = 0;
            end
        end
    endtask

    // Inputs for this cycle are set; check, advance model, cross the edge.
    task automatic step();
        compare();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_strb = '0; bus.resp_ready = 0;
        bus.aw_ready = 0; bus.w_ready = 0;
        bus.b_id = '0; bus.b_resp = '0; bus.b_valid = 0;
        bus.ar_ready = 0;
        bus.r_id = '0; bus.r_data = '0; bus.r_resp = '0;
        bus.r_last = 0; bus.r_valid = 0;
    endtask

    task automatic req(input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
        bus.req_valid = 1; bus.req_we = we; bus.req_addr = a;
        bus.req_wdata = d; bus.req_strb = s;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_busy; i++) begin
            clear_inputs();
            bus.aw_ready = 1; bus.w_ready = 1; bus.ar_ready = 1;
            bus.b_valid = 1; bus.r_valid = 1; bus.resp_ready = 1;
            step();
        end
        chk("drain_idle", bus.req_ready, 1);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_aw_valid", bus.aw_valid, 0);
        chk("rst_w_valid", bus.w_valid, 0);
        chk("rst_ar_valid", bus.ar_valid, 0);
        chk("rst_b_ready", bus.b_ready, 0);
        chk("rst_r_ready", bus.r_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_resp_code", bus.resp_code, 0);
        chk("rst_aw_addr", bus.aw_addr, 0);
        chk("rst_w_data", bus.w_data, 0);
        rst = 1;
        step();

        // zero-wait write
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            bus.aw_ready = 1; bus.w_ready = 1; bus.b_valid = 1;
            bus.resp_ready = 1;
            if (i == 0) req(1, 32'h1000, 32'hDEADBEEF, 4'hF);
            if (i == 1) begin
                chk("wr_aw_valid", bus.aw_valid, 1);
                chk("wr_aw_addr", bus.aw_addr, 32'h1000);
                chk("wr_w_data", bus.w_data, 32'hDEADBEEF);
                chk("wr_w_strb", bus.w_strb, 4'hF);
            end
            if (i == 2) chk("wr_b_ready", bus.b_ready, 1);
            if (i == 3) begin
                chk("wr_resp_valid", bus.resp_valid, 1);
                chk("wr_resp_rdata", bus.resp_rdata, 0);
                chk("wr_resp_code", bus.resp_code, 0);
            end
            if (i == 4) chk("wr_idle", bus.req_ready, 1);
            step();
        end

        // read with slow AR and delayed R
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            bus.resp_ready = 1;
            bus.ar_ready = (i == 4);
            bus.r_valid = (i == 6);
            bus.r_data = (i == 6) ? 32'h12345678 : $urandom;
            bus.r_resp = (i == 6) ? 2'd2 : 2'($urandom_range(0, 3));
            if (i == 0) req(0, 32'h2000, 32'h0, 4'h0);
            if (i >= 1 && i <= 4) begin
                chk("rd_ar_valid", bus.ar_valid, 1);
                chk("rd_ar_addr", bus.ar_addr, 32'h2000);
            end
            if (i == 5) chk("rd_r_ready", bus.r_ready, 1);
            if (i == 7) begin
                chk("rd_resp_valid", bus.resp_valid, 1);
                chk("rd_resp_rdata", bus.resp_rdata, 32'h12345678);
                chk("rd_resp_code", bus.resp_code, 2);
            end
            step();
        end

        // AW and W handshakes skewed
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            bus.resp_ready = 1; bus.b_valid = 1; bus.b_resp = 2'd1;
            bus.aw_ready = (i == 1);
            bus.w_ready = (i == 4);
            if (i == 0) req(1, 32'h3004, 32'hA5A55A5A, 4'h6);
            if (i == 2) begin
                chk("skew_aw_dropped", bus.aw_valid, 0);
                chk("skew_w_held", bus.w_valid, 1);
            end
            if (i == 4) chk("skew_b_early", bus.b_ready, 0);
            if (i == 5) begin
                chk("skew_w_dropped", bus.w_valid, 0);
                chk("skew_b_ready", bus.b_ready, 1);
            end
            if (i == 6) chk("skew_resp_code", bus.resp_code, 1);
            step();
        end

        // response backpressure with a queued request
        for (int i = 0; i < 11; i++) begin
            clear_inputs();
            bus.ar_ready = 1; bus.r_valid = 1;
            bus.r_data = (i <= 2) ? 32'hCAFEF00D : $urandom;
            bus.resp_ready = (i == 8);
            if (i == 0) req(0, 32'h4000, 32'h0, 4'h0);
            if (i >= 1 && i <= 9) req(1, 32'h5000, 32'h11223344, 4'hF);
            if (i >= 3 && i <= 8) begin
                chk("bp_resp_valid", bus.resp_valid, 1);
                chk("bp_resp_rdata", bus.resp_rdata, 32'hCAFEF00D);
                chk("bp_req_ready", bus.req_ready, 0);
            end
            if (i == 9) chk("bp_req_ready_back", bus.req_ready, 1);
            if (i == 10) chk("bp_next_aw_addr", bus.aw_addr, 32'h5000);
            step();
        end
        drain();

        // stray write response during a read
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            bus.resp_ready = 1; bus.b_valid = 1; bus.b_resp = 2'd3;
            bus.ar_ready = (i == 3);
            bus.r_valid = (i == 5);
            bus.r_data = 32'h0BADC0DE; bus.r_resp = 2'd0;
            if (i == 0) req(0, 32'h6000, 32'h0, 4'h0);
            if (i == 2 || i == 4) chk("stray_b_ready", bus.b_ready, 0);
            if (i == 6) begin
                chk("stray_resp_rdata", bus.resp_rdata, 32'h0BADC0DE);
                chk("stray_resp_code", bus.resp_code, 0);
            end
            step();
        end

        // reset in the middle of a write
        clear_inputs();
        req(1, 32'h7000, 32'h77777777, 4'hF);
        step();
        clear_inputs();
        chk("mid_aw_valid", bus.aw_valid, 1);
        step();
        rst = 0;
        #1;
        chk("mid_rst_aw_valid", bus.aw_valid, 0);
        chk("mid_rst_w_valid", bus.w_valid, 0);
        chk("mid_rst_resp_valid", bus.resp_valid, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            bus.b_valid = 1; bus.resp_ready = 1;
            step();
        end
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            bus.ar_ready = 1; bus.r_valid = 1; bus.resp_ready = 1;
            bus.r_data = 32'h55AA33CC; bus.r_resp = 2'd0;
            if (i == 0) req(0, 32'h8000, 32'h0, 4'h0);
            if (i == 3) chk("post_rst_rdata", bus.resp_rdata, 32'h55AA33CC);
            step();
        end

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            clear_inputs();
            if ($urandom_range(0, 2) != 0)
                req(1'($urandom), $urandom, $urandom, 4'($urandom));
            bus.resp_ready = ($urandom_range(0, 2) != 0);
            bus.aw_ready = ($urandom_range(0, 2) != 0);
            bus.w_ready = ($urandom_range(0, 2) != 0);
            bus.ar_ready = ($urandom_range(0, 2) != 0);
            bus.b_valid = 1'($urandom);
            bus.b_resp = 2'($urandom_range(0, 3));
            bus.b_id = 1'($urandom);
            bus.r_valid = 1'($urandom);
            bus.r_data = $urandom;
            bus.r_resp = 2'($urandom_range(0, 3));
            bus.r_id = 1'($urandom);
            bus.r_last = 1'($urandom);
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
